bin_to_bcd: RTL
===============

# bin_to_bcd

Sequential binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one input bit per clock. It is the inverse path of the team's combinational `bcd_to_bin` block and feeds display and readout logic with packed BCD digits. A start/done handshake frames each conversion. An overflow flag reports inputs that exceed the digit capacity.

## Interface
- `BIN_W`, default 14: binary input width; must be ≥ 4.
- `DIGITS`, default 4: number of BCD output digits; `out` width is 4*DIGITS.
- `clk`  input  1  rising-edge clock.
- `rst_n`  input  1  reset, synchronous and active-low.
- `start`  input  1  request a conversion; sampled only while idle.
- `in`  input  BIN_W  unsigned binary value; sampled on the accepted start edge.
- `busy`  output  1  high while a conversion is in progress.
- `done`  output  1  one-cycle pulse when `out` and `ovf` are updated.
- `out`  output  4*DIGITS  packed BCD, most significant digit in the top nibble.
- `ovf`  output  1  input exceeded 10^DIGITS−1; valid with `done`, held until the next `done`.

## Operation
- States: IDLE, CONV.
- **IDLE**
  - `start`=1 latches `in` into shift register `bin_r`.
  - Clears BCD accumulator `acc` (4*DIGITS bits).
  - Loads bit counter `cnt` = BIN_W.
  - Latches `ovf_p` = (`in` > 10^DIGITS−1); compare at BIN_W+1 bits minimum.
  - Moves to CONV.
- **CONV**, every cycle:
  - Each nibble of `acc` that is ≥5 gets +3 (all digits evaluated in parallel).
  - Then `{acc,bin_r}` shifts left by 1 as one register; the bit leaving the top of `acc` is discarded.
  - `cnt` decrements.
- **Completion** (CONV cycle with `cnt`==1):
  - Register the final result into `out`.
  - `ovf` <= `ovf_p`.
  - `done` <= 1 for one cycle; return to IDLE.
- `busy` = (state==CONV).
- `out` and `ovf` hold between conversions. Only a completion or a reset changes them.
- `start` while busy is ignored; no queueing.
- Arithmetic: each digit stays 0–9 after every shift. With truncation at the top digit, `out` = `in` mod 10^DIGITS before the saturation rule in Configuration.

## Timing
- Reset (`rst_n`=0 at a rising edge): state IDLE, `busy`=0, `done`=0, `out`=0, `ovf`=0; internal registers cleared.
- Reset mid-conversion aborts it. No `done` is produced, and `out` reads 0.
- Latency: `start` accepted at edge E0. CONV runs for edges E1..E_BIN_W. `out`, `ovf` and `done` are updated at E_BIN_W, so `done` is high BIN_W cycles after acceptance.
- Throughput: `done` is high while state is already IDLE, so a `start` in the `done` cycle is accepted. Back-to-back period is BIN_W+1 cycles.
- `in` may change freely after the accepting edge.
- `start` and `rst_n`=0 at the same edge: reset wins.

## Configuration
- `BIN_TO_BCD_SAT_EN`
  - Defined: when `ovf_p`=1, completion loads `out` with all digits 9 (for example 16'h9999 at DIGITS=4).
  - Undefined: `out` = `in` mod 10^DIGITS (natural truncation).
- `ovf` is reported identically in both builds.

## Test plan
- Reset, then `in`=0, `start` for one cycle → `busy` high for 14 cycles; `done` at edge 14; `out`=16'h0000, `ovf`=0.
- `in`=1234 → `out`=16'h1234, `ovf`=0. Then `in`=9999 → `out`=16'h9999, `ovf`=0.
- `in`=10000 → `ovf`=1. `out`=16'h9999 with `BIN_TO_BCD_SAT_EN`, 16'h0000 without. Also `in`=16383 → `ovf`=1; `out`=16'h9999 or 16'h6383.
- `start` pulsed at cycle 5 of a busy conversion of 42 → ignored; single `done` with `out`=16'h0042.
- `start`=1 during the `done` cycle with `in`=77 → accepted; second `done` exactly 15 cycles after the first; `out`=16'h0077.
- `rst_n` low at cycle 7 of a conversion of 5678 → no `done`, `out`=0, `busy`=0. Then run 10 random values 0–9999, each checked by round-tripping `out` through `bcd_to_bin` equal to `in`.

Source files
------------

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per clock.
// Define BIN_TO_BCD_SAT_EN to saturate the output to all nines on overflow.
module bin_to_bcd #(
  parameter int BIN_W  = 14,
  parameter int DIGITS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      in,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   out,
  output logic                  ovf
);

  localparam int ACC_W = 4 * DIGITS;
  localparam int CNT_W = $clog2(BIN_W + 1);
  // Wide enough for both the input (plus one bit) and 10^DIGITS-1.
  localparam int CMP_W = (BIN_W + 1 > ACC_W + 1) ? BIN_W + 1 : ACC_W + 1;

  function automatic logic [CMP_W-1:0] max_dec();
    logic [CMP_W-1:0] v;
    v = CMP_W'(1);
    for (int i = 0; i < DIGITS; i++) v = v * CMP_W'(10);
    return v - CMP_W'(1);
  endfunction

  localparam logic [CMP_W-1:0] MAX_DEC = max_dec();

  typedef enum logic {IDLE, CONV} state_t;

  state_t           state;
  logic [BIN_W-1:0] bin_r;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] cnt;
  logic             ovf_p;

  logic [ACC_W-1:0] adj;
  logic [ACC_W-1:0] acc_nx;
  logic [3:0]       nib;

  // Add-3 correction on every digit, evaluated in parallel.
  always_comb begin
    // NOTE: defaults first so no path through this block leaves a variable unassigned (no latch).
    adj = acc;
    nib = 4'd0;
    for (int d = 0; d < DIGITS; d++) begin
      nib = acc[4*d +: 4];
      if (nib >= 4'd5) nib = nib + 4'd3;
      adj[4*d +: 4] = nib;
    end
  end

  // Top bit of the corrected accumulator falls off: natural mod 10^DIGITS.
  assign acc_nx = (adj << 1) | ACC_W'(bin_r[BIN_W-1]);
  assign busy   = (state == CONV);

  always_ff @(posedge clk) begin
    // NOTE: synchronous reset clears every register; all state uses non-blocking assignments.
    if (!rst_n) begin
      state <= IDLE;
      bin_r <= '0;
      acc   <= '0;
      cnt   <= '0;
      ovf_p <= 1'b0;
      done  <= 1'b0;
      out   <= '0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            bin_r <= in;
            acc   <= '0;
            cnt   <= CNT_W'(BIN_W);
            ovf_p <= (CMP_W'(in) > MAX_DEC);
            state <= CONV;
          end
        end
        CONV: begin
          acc   <= acc_nx;
          bin_r <= bin_r << 1;
          cnt   <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) begin
`ifdef BIN_TO_BCD_SAT_EN
            out <= ovf_p ? {DIGITS{4'h9}} : acc_nx;
`else
            out <= acc_nx;
`endif
            ovf   <= ovf_p;
            done  <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
